// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the four-slot TDM demultiplexer.
// Configuration macro honoured by the top level: TDM_DEMUX4_ERRCNT_EN.
package tdm_demux4_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  localparam slot_t      SLOT_FIRST  = 2'd0;
  localparam slot_t      SLOT_SECOND = 2'd1;
  localparam slot_t      SLOT_LAST   = 2'(NUM_SLOTS - 1);
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Two-bit slot arithmetic wraps naturally at NUM_SLOTS.
  function automatic slot_t slot_inc(input slot_t s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer: clear, restart-at-slot-1 and
// modulo-4 advance, with a flag for the final slot of a frame.
module tdm_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  restart,
  input  logic  advance,
  output slot_t slot,
  output logic  last
);

  slot_t slot_r;
  slot_t slot_next_s;

  // Next slot: clear beats restart beats advance.
  always_comb begin
    slot_next_s = slot_r;
    if (clear) begin
      slot_next_s = SLOT_FIRST;
    end else if (restart) begin
      slot_next_s = SLOT_SECOND;
    end else if (advance) begin
      slot_next_s = slot_inc(slot_r);
    end else begin
      slot_next_s = slot_r;
    end
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r <= SLOT_FIRST;
    end else begin
      slot_r <= slot_next_s;
    end
  end

  assign slot = slot_r;
  assign last = (slot_r == SLOT_LAST);

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer with sof-based framing and resync.
// Optional saturating framing-error counter: define TDM_DEMUX4_ERRCNT_EN.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sof,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         frame_valid,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         sync_err,
  output logic [7:0]   err_cnt
);

  state_t       state_r;
  state_t       state_next_s;
  slot_t        slot_s;
  logic         last_s;
  logic         clear_s;
  logic         restart_s;
  logic         advance_s;
  logic         store_first_s;
  logic         store_slot_s;
  logic         load_frame_s;
  logic         err_s;
  logic [W-1:0] shadow0_r;
  logic [W-1:0] shadow1_r;
  logic [W-1:0] shadow2_r;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] c_r;
  logic [W-1:0] d_r;
  logic         frame_valid_r;
  logic         sync_err_r;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_s),
    .restart (restart_s),
    .advance (advance_s),
    .slot    (slot_s),
    .last    (last_s)
  );

  // Framing FSM: next state and per-sample control strobes.
  always_comb begin
    state_next_s  = state_r;
    clear_s       = 1'b0;
    restart_s     = 1'b0;
    advance_s     = 1'b0;
    store_first_s = 1'b0;
    store_slot_s  = 1'b0;
    load_frame_s  = 1'b0;
    err_s         = 1'b0;
    case (state_r)
      HUNT: begin
        if (din_valid && sof) begin
          restart_s     = 1'b1;
          store_first_s = 1'b1;
          state_next_s  = LOCKED;
        end else begin
          state_next_s  = HUNT;
        end
      end
      LOCKED: begin
        if (!din_valid) begin
          state_next_s = LOCKED;
        end else if (sof) begin
          // A sof mid-frame abandons the partial frame and restarts here.
          restart_s     = 1'b1;
          store_first_s = 1'b1;
          err_s         = (slot_s != SLOT_FIRST);
          state_next_s  = LOCKED;
        end else if (slot_s == SLOT_FIRST) begin
          err_s        = 1'b1;
          clear_s      = 1'b1;
          state_next_s = HUNT;
        end else begin
          advance_s     = 1'b1;
          store_slot_s  = 1'b1;
          load_frame_s  = last_s;
          state_next_s  = LOCKED;
        end
      end
      default: begin
        clear_s      = 1'b1;
        state_next_s = HUNT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Shadow capture of slots 0..2; slot 3 goes straight to d.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow0_r <= '0;
      shadow1_r <= '0;
      shadow2_r <= '0;
    end else if (store_first_s) begin
      shadow0_r <= din;
    end else if (store_slot_s) begin
      case (slot_s)
        2'd1:    shadow1_r <= din;
        2'd2:    shadow2_r <= din;
        default: shadow0_r <= shadow0_r;
      endcase
    end
  end

  // Parallel frame output load and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r           <= '0;
      b_r           <= '0;
      c_r           <= '0;
      d_r           <= '0;
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
    end else begin
      frame_valid_r <= load_frame_s;
      sync_err_r    <= err_s;
      if (load_frame_s) begin
        a_r <= shadow0_r;
        b_r <= shadow1_r;
        c_r <= shadow2_r;
        d_r <= din;
      end
    end
  end

`ifdef TDM_DEMUX4_ERRCNT_EN
  logic [7:0] err_cnt_r;

  // Saturating framing-error counter, advanced with each sync_err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= 8'd0;
    end else if (err_s && (err_cnt_r != ERR_CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = 8'd0;
`endif

  assign a           = a_r;
  assign b           = b_r;
  assign c           = c_r;
  assign d           = d_r;
  assign frame_valid = frame_valid_r;
  assign sync_err    = sync_err_r;
  assign slot        = slot_s;
  assign locked      = (state_r == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: directed frames, framing errors, gaps, reset.
module tb_tdm_demux4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sof;
  logic [W-1:0] a, b, c, d;
  logic         frame_valid;
  logic [1:0]   slot;
  logic         locked;
  logic         sync_err;
  logic [7:0]   err_cnt;

  int tests = 0;
  int fails = 0;
  int pend_err = 0;
  int n_err = 0;
  logic [4*W-1:0] exp_q[$];

  tdm_demux4 #(.W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .a(a), .b(b), .c(c), .d(d), .frame_valid(frame_valid), .slot(slot),
    .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef TDM_DEMUX4_ERRCNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  // Monitor: every frame_valid / sync_err pulse must match a queued expectation.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL frame_unexpected: got %h, expected no frame", {a, b, c, d});
      end else begin
        check("frame_abcd", 32'({a, b, c, d}), 32'(exp_q.pop_front()));
      end
    end
    if (sync_err === 1'b1) begin
      tests++;
      if (pend_err == 0) begin
        fails++;
        $display("FAIL sync_err_unexpected: got 1, expected 0");
      end else begin
        pend_err--;
      end
    end
  end

  task automatic send(input logic s, input logic [W-1:0] v);
    din_valid = 1'b1; sof = s; din = v;
    @(posedge clk); #1;
    din_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0; sof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [W-1:0] ea, eb, ec, ed);
    exp_q.push_back({ea, eb, ec, ed});
  endtask

  task automatic push_err();
    pend_err++;
    n_err++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a sof sample presented: it must be ignored.
    rst = 1'b1; din_valid = 1'b1; sof = 1'b1; din = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; din_valid = 1'b0; sof = 1'b0;
    check("rst_abcd", 32'({a, b, c, d}), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_slot", 32'(slot), 32'h0);
    check("rst_errcnt", 32'(err_cnt), 32'(exp_cnt(0)));

    // Samples without sof while hunting are discarded silently.
    send(1'b0, 4'h5); send(1'b0, 4'h6); send(1'b0, 4'h7);
    check("hunt_locked", 32'(locked), 32'h0);
    check("hunt_slot", 32'(slot), 32'h0);
    check("hunt_abcd", 32'({a, b, c, d}), 32'h0);

    // First frame 0,1,0,1, immediately followed by 9,A,B,C back to back.
    send(1'b1, 4'h0);
    check("lock_locked", 32'(locked), 32'h1);
    check("lock_slot", 32'(slot), 32'h1);
    send(1'b0, 4'h1); send(1'b0, 4'h0);
    check("slot3_pending", 32'(slot), 32'h3);
    push_frame(4'h0, 4'h1, 4'h0, 4'h1);
    send(1'b0, 4'h1);
    check("wrap_slot", 32'(slot), 32'h0);
    send(1'b1, 4'h9); send(1'b0, 4'hA); send(1'b0, 4'hB);
    push_frame(4'h9, 4'hA, 4'hB, 4'hC);
    send(1'b0, 4'hC);

    // sof on the third sample restarts the frame from that sample.
    send(1'b1, 4'h1); send(1'b0, 4'h2);
    push_err();
    send(1'b1, 4'h3);
    check("resync_slot", 32'(slot), 32'h1);
    check("resync_locked", 32'(locked), 32'h1);
    send(1'b0, 4'h4); send(1'b0, 4'h5);
    push_frame(4'h3, 4'h4, 4'h5, 4'h6);
    send(1'b0, 4'h6);
    idle(1);
    check("errcnt_1", 32'(err_cnt), 32'(exp_cnt(n_err)));

    // Missing sof at slot 0 drops lock; the next sof relocks.
    push_err();
    send(1'b0, 4'h7);
    check("drop_locked", 32'(locked), 32'h0);
    check("drop_slot", 32'(slot), 32'h0);
    idle(1);
    check("errcnt_2", 32'(err_cnt), 32'(exp_cnt(n_err)));

    // Relock with 5-cycle gaps between samples.
    send(1'b1, 4'h8); idle(5);
    check("relock_locked", 32'(locked), 32'h1);
    send(1'b0, 4'h9); idle(5);
    send(1'b0, 4'hA); idle(5);
    check("gap_hold_abcd", 32'({a, b, c, d}), 32'h3456);
    check("gap_slot", 32'(slot), 32'h3);
    push_frame(4'h8, 4'h9, 4'hA, 4'hB);
    send(1'b0, 4'hB); idle(5);

    // Reset mid-frame after slot 2 discards everything.
    send(1'b1, 4'h1); send(1'b0, 4'h2); send(1'b0, 4'h3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_slot", 32'(slot), 32'h0);
    check("midrst_locked", 32'(locked), 32'h0);
    check("midrst_abcd", 32'({a, b, c, d}), 32'h0);
    check("midrst_errcnt", 32'(err_cnt), 32'(exp_cnt(0)));
    send(1'b0, 4'h4);
    idle(4);
    check("midrst_hunt", 32'(locked), 32'h0);

    check("frames_outstanding", 32'(exp_q.size()), 32'h0);
    check("errs_outstanding", 32'(pend_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: W, default 1, sample width in bits of each channel.
REQ-002 clk  input  1  rising-edge clock; all state changes on it.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 din  input  W  serialized time-division sample stream.
REQ-005 din_valid  input  1  din carries a sample this cycle.
REQ-006 sof  input  1  start-of-frame; qualifies the din sample as slot 0; ignored when din_valid=0.
REQ-007 a, b, c, d  output  W each  channel 0..3 sample of the last complete frame, registered.
REQ-008 frame_valid  output  1  one-cycle pulse; a..d were just updated with a new frame.
REQ-009 slot  output  2  slot index the next accepted sample will fill.
REQ-010 locked  output  1  high in state LOCKED.
REQ-011 sync_err  output  1  one-cycle pulse on a framing violation.
REQ-012 err_cnt  output  8  framing-error count.

Function
REQ-013 FSM SHALL have two states: HUNT and LOCKED.
REQ-014 In HUNT, samples with sof=0 SHALL be discarded without raising sync_err.
REQ-015 In HUNT, din_valid=1 with sof=1 SHALL store din in shadow slot 0, set slot to 1 and enter LOCKED.
REQ-016 In LOCKED, each din_valid=1 with sof=0 and slot in 1..3 SHALL store din in shadow slot[slot] and increment slot modulo 4.
REQ-017 On acceptance of slot 3, a..d SHALL load in parallel on the same edge: shadow 0..2 into a..c and din into d; slot SHALL wrap to 0.
REQ-018 frame_valid SHALL be high for exactly the cycle after the slot-3 edge (latency 1 clock from the slot-3 sample).
REQ-019 In LOCKED with slot=0, din_valid=1 with sof=1 SHALL start the next frame exactly as in REQ-015.
REQ-020 In LOCKED with slot=0, din_valid=1 with sof=0 SHALL pulse sync_err, discard the sample and enter HUNT.
REQ-021 In LOCKED with slot in 1..3, din_valid=1 with sof=1 SHALL pulse sync_err, drop the partial frame and restart at slot 0 with this sample (slot becomes 1, stays LOCKED).
REQ-022 din_valid=0 cycles SHALL leave all state unchanged; gaps of any length inside a frame are legal.
REQ-023 a..d SHALL never show a partial frame; they change only on a slot-3 acceptance.
REQ-024 Back-to-back frames (din_valid held at 1) SHALL produce a frame_valid pulse every 4 cycles.

Reset
REQ-025 rst=1 SHALL, on the next clk edge, force HUNT, slot=0, locked=0, a=b=c=d=0, shadow=0, frame_valid=0, sync_err=0 and err_cnt=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid pulse follows.
REQ-027 Samples presented while rst=1 SHALL be ignored.

Configuration
REQ-028 Macro TDM_DEMUX4_ERRCNT_EN defined: err_cnt SHALL increment on each sync_err pulse, saturate at 255 and clear only on rst.
REQ-029 Macro TDM_DEMUX4_ERRCNT_EN undefined: err_cnt SHALL be constant 0, the port SHALL remain present and no counter register SHALL be synthesized.

Structure
REQ-030 Package tdm_demux4_pkg SHALL hold the state enum (HUNT, LOCKED), constant NUM_SLOTS=4 and the 2-bit slot type.
REQ-031 The slot counter with its wrap and restart logic SHALL be a sub-module, tdm_slot_ctr.

Verification
REQ-032 Reset, then a frame of samples 0,1,0,1 (W=1) with sof on the first -> a=0, b=1, c=0, d=1; frame_valid pulses one cycle after the 4th sample.
REQ-033 Samples before any sof in HUNT -> a..d stay 0, sync_err stays 0, locked=0.
REQ-034 sof on the 3rd sample of a frame -> sync_err pulse and err_cnt=1 (macro defined); the next three samples complete a frame beginning at that 3rd sample.
REQ-035 After a full frame, next sample without sof -> sync_err pulse, locked=0; next sof sample relocks.
REQ-036 Frame with 5-cycle din_valid gaps between samples -> same outputs as the gapless frame, one frame_valid pulse.
REQ-037 rst asserted after slot 2 -> next edge gives slot=0, locked=0, a..d=0 and no frame_valid pulse.
